// File: rtl/eee_imgproc_multi.sv
// eee_imgproc_multi: Avalon-ST video colour-class filter with per-class bounding boxes.
//
// One registered pipeline stage between sink and source. The first beat of each
// packet is a header; a low nibble of zero marks a video packet. Video pixels are
// tested against NUM_CLASSES inclusive {R,G,B} windows. Matches drive the output
// recolouring and per-class min/max x/y accumulators. Those accumulators are latched
// into the bbox_* outputs on the video packet's eop, with a one-cycle bbox_valid pulse.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   sink_*                       Avalon-ST video in ({R,G,B}), sink_ready backpressure
//   source_*                     Avalon-ST video out, source_ready from downstream
//   mode                         0 pass, 1 highlight, 2 binary mask, 3 bbox overlay
//   thr_lo / thr_hi              per-class inclusive bounds, class k at [24k+23:24k]
//   bbox_x_min/x_max             per-class column bounds (11 bits per class)
//   bbox_y_min/y_max             per-class row bounds (10 bits per class)
//   bbox_found                   class hit at least once in the last latched frame
//   bbox_valid                   one-cycle pulse when bbox_* update
//
// Optional feature: define EEE_IMGPROC_BBOX_OVERLAY_EN to build the mode-3 outline
// overlay; without it mode 3 behaves as mode 0.
module eee_imgproc_multi #(
  parameter int unsigned IMAGE_W     = 640,
  parameter int unsigned IMAGE_H     = 480,
  parameter int unsigned NUM_CLASSES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [23:0]               sink_data,
  input  logic                      sink_valid,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  output logic                      sink_ready,
  output logic [23:0]               source_data,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  input  logic                      source_ready,
  input  logic [1:0]                mode,
  input  logic [24*NUM_CLASSES-1:0] thr_lo,
  input  logic [24*NUM_CLASSES-1:0] thr_hi,
  output logic [11*NUM_CLASSES-1:0] bbox_x_min,
  output logic [11*NUM_CLASSES-1:0] bbox_x_max,
  output logic [10*NUM_CLASSES-1:0] bbox_y_min,
  output logic [10*NUM_CLASSES-1:0] bbox_y_max,
  output logic [NUM_CLASSES-1:0]    bbox_found,
  output logic                      bbox_valid
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned NC = NUM_CLASSES;
  localparam logic [XW-1:0] XLast  = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] YLimit = YW'(IMAGE_H);

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Pipeline output register
  logic [23:0] src_data_q;
  logic        src_valid_q, src_sop_q, src_eop_q;

  // Packet tracking
  logic          in_video_q;
  logic [1:0]    mode_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Accumulators and latched results
  logic [NC-1:0] acc_found_q, acc_found_d;
  logic [XW-1:0] acc_xmin_q [NC];
  logic [XW-1:0] acc_xmax_q [NC];
  logic [YW-1:0] acc_ymin_q [NC];
  logic [YW-1:0] acc_ymax_q [NC];
  logic [XW-1:0] acc_xmin_d [NC];
  logic [XW-1:0] acc_xmax_d [NC];
  logic [YW-1:0] acc_ymin_d [NC];
  logic [YW-1:0] acc_ymax_d [NC];
  logic [NC-1:0] bb_found_q;
  logic [XW-1:0] bb_xmin_q [NC];
  logic [XW-1:0] bb_xmax_q [NC];
  logic [YW-1:0] bb_ymin_q [NC];
  logic [YW-1:0] bb_ymax_q [NC];
  logic          bb_valid_q;

  logic          accept, hdr_video, is_pix, pix_in_frame, latch, any_match;
  logic [NC-1:0] match;
  logic [23:0]   pix_out;

  assign sink_ready   = source_ready | ~src_valid_q;
  assign accept       = sink_valid & sink_ready;
  assign hdr_video    = sink_sop & (sink_data[3:0] == 4'h0);
  assign is_pix       = ~sink_sop & in_video_q;
  // Lines past IMAGE_H still flow through but never touch the accumulators.
  assign pix_in_frame = is_pix & (y_q < YLimit);
  // A header-only video packet also latches (an all-empty result).
  assign latch        = accept & sink_eop & (hdr_video | is_pix);

  always_comb begin
    match = '0;
    for (int k = 0; k < NC; k++) begin
      match[k] = in_range(sink_data[23:16], thr_lo[24*k+16 +: 8], thr_hi[24*k+16 +: 8]) &
                 in_range(sink_data[15:8],  thr_lo[24*k+8  +: 8], thr_hi[24*k+8  +: 8]) &
                 in_range(sink_data[7:0],   thr_lo[24*k    +: 8], thr_hi[24*k    +: 8]);
    end
  end
  assign any_match = |match;

`ifdef EEE_IMGPROC_BBOX_OVERLAY_EN
  logic on_outline;
  always_comb begin
    on_outline = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (bb_found_q[k] &&
          (((x_q == bb_xmin_q[k]) || (x_q == bb_xmax_q[k])) &&
            (y_q >= bb_ymin_q[k]) && (y_q <= bb_ymax_q[k]) ||
           ((y_q == bb_ymin_q[k]) || (y_q == bb_ymax_q[k])) &&
            (x_q >= bb_xmin_q[k]) && (x_q <= bb_xmax_q[k]))) begin
        on_outline = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    pix_out = sink_data;
    if (is_pix) begin
      case (mode_q)
        2'd1: if (any_match) pix_out = 24'hFFFFFF;
        2'd2: pix_out = any_match ? 24'hFFFFFF : 24'h000000;
`ifdef EEE_IMGPROC_BBOX_OVERLAY_EN
        2'd3: if (on_outline) pix_out = 24'h00FF00;
`endif
        default: pix_out = sink_data;
      endcase
    end
  end

  // Next accumulator state for the beat on the sink; sop discards whatever was in flight.
  always_comb begin
    acc_found_d = acc_found_q;
    acc_xmin_d  = acc_xmin_q;
    acc_xmax_d  = acc_xmax_q;
    acc_ymin_d  = acc_ymin_q;
    acc_ymax_d  = acc_ymax_q;
    if (sink_sop) begin
      acc_found_d = '0;
      for (int k = 0; k < NC; k++) begin
        acc_xmin_d[k] = '0;
        acc_xmax_d[k] = '0;
        acc_ymin_d[k] = '0;
        acc_ymax_d[k] = '0;
      end
    end else if (pix_in_frame) begin
      for (int k = 0; k < NC; k++) begin
        if (match[k]) begin
          acc_found_d[k] = 1'b1;
          if (!acc_found_q[k]) begin
            acc_xmin_d[k] = x_q;
            acc_xmax_d[k] = x_q;
            acc_ymin_d[k] = y_q;
            acc_ymax_d[k] = y_q;
          end else begin
            if (x_q < acc_xmin_q[k]) acc_xmin_d[k] = x_q;
            if (x_q > acc_xmax_q[k]) acc_xmax_d[k] = x_q;
            if (y_q < acc_ymin_q[k]) acc_ymin_d[k] = y_q;
            if (y_q > acc_ymax_q[k]) acc_ymax_d[k] = y_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_data_q  <= '0;
    end else if (accept) begin
      src_valid_q <= 1'b1;
      src_sop_q   <= sink_sop;
      src_eop_q   <= sink_eop;
      src_data_q  <= pix_out;
    end else if (source_ready) begin
      src_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_video_q <= 1'b0;
      mode_q     <= 2'd0;
      x_q        <= '0;
      y_q        <= '0;
    end else if (accept) begin
      if (sink_sop) begin
        in_video_q <= hdr_video & ~sink_eop;
        x_q        <= '0;
        y_q        <= '0;
        if (hdr_video) mode_q <= mode;
      end else begin
        if (sink_eop) in_video_q <= 1'b0;
        if (is_pix) begin
          if (x_q == XLast) begin
            x_q <= '0;
            // Saturate so long packets cannot wrap back into the frame.
            if (y_q != YLimit) y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_found_q <= '0;
      bb_found_q  <= '0;
      bb_valid_q  <= 1'b0;
      for (int k = 0; k < NC; k++) begin
        acc_xmin_q[k] <= '0;
        acc_xmax_q[k] <= '0;
        acc_ymin_q[k] <= '0;
        acc_ymax_q[k] <= '0;
        bb_xmin_q[k]  <= '0;
        bb_xmax_q[k]  <= '0;
        bb_ymin_q[k]  <= '0;
        bb_ymax_q[k]  <= '0;
      end
    end else begin
      bb_valid_q <= latch;
      if (latch) begin
        bb_found_q  <= acc_found_d;
        acc_found_q <= '0;
        for (int k = 0; k < NC; k++) begin
          bb_xmin_q[k]  <= acc_xmin_d[k];
          bb_xmax_q[k]  <= acc_xmax_d[k];
          bb_ymin_q[k]  <= acc_ymin_d[k];
          bb_ymax_q[k]  <= acc_ymax_d[k];
          acc_xmin_q[k] <= '0;
          acc_xmax_q[k] <= '0;
          acc_ymin_q[k] <= '0;
          acc_ymax_q[k] <= '0;
        end
      end else if (accept) begin
        acc_found_q <= acc_found_d;
        acc_xmin_q  <= acc_xmin_d;
        acc_xmax_q  <= acc_xmax_d;
        acc_ymin_q  <= acc_ymin_d;
        acc_ymax_q  <= acc_ymax_d;
      end
    end
  end

  assign source_data  = src_data_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign bbox_found   = bb_found_q;
  assign bbox_valid   = bb_valid_q;

  always_comb begin
    for (int k = 0; k < NC; k++) begin
      bbox_x_min[XW*k +: XW] = bb_xmin_q[k];
      bbox_x_max[XW*k +: XW] = bb_xmax_q[k];
      bbox_y_min[YW*k +: YW] = bb_ymin_q[k];
      bbox_y_max[YW*k +: YW] = bb_ymax_q[k];
    end
  end

endmodule

// File: tb/tb_eee_imgproc_multi.sv
// Testbench for eee_imgproc_multi (IMAGE_W=8, IMAGE_H=4, NUM_CLASSES=2).
module tb_eee_imgproc_multi;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop, source_ready;
  logic [1:0]  mode;
  logic [47:0] thr_lo, thr_hi;
  logic [21:0] bx_min, bx_max;
  logic [19:0] by_min, by_max;
  logic [1:0]  bfound;
  logic        bvalid;

  eee_imgproc_multi #(.IMAGE_W(W), .IMAGE_H(H), .NUM_CLASSES(NC)) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .mode(mode), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .bbox_x_min(bx_min), .bbox_x_max(bx_max), .bbox_y_min(by_min), .bbox_y_max(by_max),
    .bbox_found(bfound), .bbox_valid(bvalid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int rdy_mode = 0;  // 0 ready held high, 1 toggle every cycle, 2 held low
  bit chk_rdy = 0;
  logic [25:0] exp_q[$];
  logic [25:0] got_q[$];
  int pulses = 0;
  int exp_pulses = 0;

  // Reference model state
  bit m_vid;
  int m_mode, m_idx;
  bit hit[NC][W*H];
  bit m_found[NC];
  int m_xmin[NC], m_xmax[NC], m_ymin[NC], m_ymax[NC];
  logic [23:0] px[64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) source_ready = ~source_ready;
    else if (rdy_mode == 2) source_ready = 1'b0;
    else source_ready = 1'b1;
  end

  logic [25:0] prev_beat;
  bit prev_stall = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(source_valid), 64'd1);
        chk("stall_hold", 64'({source_sop, source_eop, source_data}), 64'(prev_beat));
      end
      if (chk_rdy) chk("sink_ready", 64'(sink_ready), 64'd1);
      if (source_valid && source_ready) got_q.push_back({source_sop, source_eop, source_data});
      if (bvalid) pulses++;
      prev_stall = source_valid && !source_ready;
      prev_beat  = {source_sop, source_eop, source_data};
    end
  end

  function automatic bit cls_match(input int k, input logic [23:0] d);
    for (int c = 0; c < 3; c++) begin
      int v, lo, hi;
      v  = int'(d[8*c +: 8]);
      lo = int'(thr_lo[24*k + 8*c +: 8]);
      hi = int'(thr_hi[24*k + 8*c +: 8]);
      if (v < lo || v > hi) return 1'b0;
    end
    return 1'b1;
  endfunction

`ifdef EEE_IMGPROC_BBOX_OVERLAY_EN
  function automatic bit on_box(input int x, input int y);
    for (int k = 0; k < NC; k++) begin
      if (m_found[k]) begin
        if ((x == m_xmin[k] || x == m_xmax[k]) && y >= m_ymin[k] && y <= m_ymax[k]) return 1'b1;
        if ((y == m_ymin[k] || y == m_ymax[k]) && x >= m_xmin[k] && x <= m_xmax[k]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction
`endif

  task automatic model_reset();
    m_vid = 0; m_mode = 0; m_idx = 0;
    for (int k = 0; k < NC; k++) begin
      m_found[k] = 0; m_xmin[k] = 0; m_xmax[k] = 0; m_ymin[k] = 0; m_ymax[k] = 0;
      for (int i = 0; i < W*H; i++) hit[k][i] = 0;
    end
  endtask

  // Bounding box of each class taken from the frame's hit map.
  task automatic model_latch();
    for (int k = 0; k < NC; k++) begin
      m_found[k] = 0; m_xmin[k] = 0; m_xmax[k] = 0; m_ymin[k] = 0; m_ymax[k] = 0;
      for (int i = 0; i < W*H; i++) begin
        if (hit[k][i]) begin
          if (!m_found[k]) begin
            m_found[k] = 1; m_xmin[k] = i % W; m_xmax[k] = i % W;
            m_ymin[k] = i / W; m_ymax[k] = i / W;
          end else begin
            if (i % W < m_xmin[k]) m_xmin[k] = i % W;
            if (i % W > m_xmax[k]) m_xmax[k] = i % W;
            if (i / W > m_ymax[k]) m_ymax[k] = i / W;
          end
        end
      end
    end
    exp_pulses++;
  endtask

  task automatic model_beat(input logic [23:0] d, input logic s, input logic e,
                            output logic [23:0] o);
    int x, y;
    bit anym;
    o = d;
    if (s) begin
      m_vid = (d[3:0] == 4'h0);
      m_idx = 0;
      for (int k = 0; k < NC; k++) for (int i = 0; i < W*H; i++) hit[k][i] = 0;
      if (m_vid) m_mode = int'(mode);
      if (m_vid && e) model_latch();
    end else if (m_vid) begin
      x = m_idx % W;
      y = m_idx / W;
      anym = 0;
      for (int k = 0; k < NC; k++) begin
        if (cls_match(k, d)) begin
          anym = 1;
          if (y < H) hit[k][m_idx] = 1;
        end
      end
      if (m_mode == 1 && anym) o = 24'hFFFFFF;
      else if (m_mode == 2) o = anym ? 24'hFFFFFF : 24'h000000;
`ifdef EEE_IMGPROC_BBOX_OVERLAY_EN
      else if (m_mode == 3 && on_box(x, y)) o = 24'h00FF00;
`endif
      m_idx++;
      if (e) model_latch();
    end
    if (e) m_vid = 0;
  endtask

  // Drive one beat, wait for acceptance, then check it appeared one cycle later.
  task automatic send(input logic [23:0] d, input logic s, input logic e);
    logic [23:0] o;
    bit taken;
    int guard;
    model_beat(d, s, e, o);
    exp_q.push_back({s, e, o});
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    guard = 0;
    taken = 0;
    while (!taken && guard < 200) begin
      @(negedge clk);
      taken = sink_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    sink_valid = 1'b0;
    if (!taken) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      chk("lat_valid", 64'(source_valid), 64'd1);
      chk("lat_beat", 64'({source_sop, source_eop, source_data}), 64'({s, e, o}));
    end
  endtask

  task automatic fill_bg(input int n);
    for (int i = 0; i < n; i++) px[i] = 24'($urandom) & 24'h7F7F7F;
  endtask

  task automatic send_frame(input logic [1:0] m, input int n, input bit with_eop);
    logic [23:0] hd;
    hd = 24'($urandom) & 24'hFFFFF0;
    mode = m;
    send(hd, 1'b1, with_eop && n == 0);
    for (int i = 0; i < n; i++) send(px[i], 1'b0, with_eop && i == n - 1);
  endtask

  task automatic check_bbox(input string tag);
    for (int k = 0; k < NC; k++) begin
      chk({tag, "_found"}, 64'(bfound[k]), 64'(m_found[k]));
      chk({tag, "_xmin"}, 64'(bx_min[11*k +: 11]), 64'(m_xmin[k]));
      chk({tag, "_xmax"}, 64'(bx_max[11*k +: 11]), 64'(m_xmax[k]));
      chk({tag, "_ymin"}, 64'(by_min[10*k +: 10]), 64'(m_ymin[k]));
      chk({tag, "_ymax"}, 64'(by_max[10*k +: 10]), 64'(m_ymax[k]));
    end
    chk({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
  endtask

  task automatic check_frame(input string tag);
    int n;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    check_bbox(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_src_valid"}, 64'(source_valid), 64'd0);
    chk({tag, "_src_sop"}, 64'(source_sop), 64'd0);
    chk({tag, "_src_eop"}, 64'(source_eop), 64'd0);
    chk({tag, "_src_data"}, 64'(source_data), 64'd0);
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd0);
    chk({tag, "_bfound"}, 64'(bfound), 64'd0);
    chk({tag, "_bxmin"}, 64'(bx_min), 64'd0);
    chk({tag, "_bxmax"}, 64'(bx_max), 64'd0);
    chk({tag, "_bymin"}, 64'(by_min), 64'd0);
    chk({tag, "_bymax"}, 64'(by_max), 64'd0);
  endtask

  initial begin
    reset = 1'b1; sink_valid = 0; sink_data = '0; sink_sop = 0; sink_eop = 0;
    mode = 2'd0; source_ready = 1'b1;
    thr_lo = {24'h0000C0, 24'h800000};  // class1 blue, class0 red
    thr_hi = {24'h3F3FFF, 24'hFF3F3F};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Pass-through frame with ready held high
    chk_rdy = 1;
    fill_bg(32);
    send_frame(2'd0, 32, 1);
    check_frame("pass");
    chk_rdy = 0;

    // Two red pixels
    fill_bg(32);
    px[10] = 24'hFF1010;
    px[29] = 24'hC02030;
    send_frame(2'd0, 32, 1);
    check_frame("bbox");
    chk("bbox0_const_found", 64'(bfound), 64'd1);
    chk("bbox0_const_x", 64'({bx_min[10:0], bx_max[10:0]}), 64'({11'd2, 11'd5}));
    chk("bbox0_const_y", 64'({by_min[9:0], by_max[9:0]}), 64'({10'd1, 10'd3}));

    // Binary mask, one blue pixel
    fill_bg(32);
    px[$urandom_range(0, 31)] = 24'h1020E0;
    send_frame(2'd2, 32, 1);
    check_frame("mask");
    chk("mask_const_found", 64'(bfound), 64'd2);

    // Highlight with random pixels under toggling backpressure
    for (int i = 0; i < 32; i++) px[i] = 24'($urandom);
    rdy_mode = 1;
    send_frame(2'd1, 32, 1);
    check_frame("stall");

    // Control packet between frames
    send(24'($urandom) | 24'h00000F, 1'b1, 1'b0);
    send(24'($urandom), 1'b0, 1'b0);
    send(24'($urandom), 1'b0, 1'b1);
    check_frame("ctrl");
    fill_bg(32);
    px[17] = 24'hFF0000;
    send_frame(2'd0, 32, 1);
    check_frame("after_ctrl");
    chk("after_ctrl_const", 64'({bx_min[10:0], by_min[9:0]}), 64'({11'd1, 10'd2}));

    // sop after 10 pixels, then a full frame
    fill_bg(10);
    px[3] = 24'hFF0000;
    send_frame(2'd0, 10, 0);
    fill_bg(32);
    px[31] = 24'hFF0000;
    send_frame(2'd0, 32, 1);
    check_frame("restart");
    chk("restart_const", 64'({bx_min[10:0], by_min[9:0]}), 64'({11'd7, 10'd3}));

    // Extra line past IMAGE_H is passed but not counted
    fill_bg(40);
    px[5]  = 24'hFF0000;
    px[33] = 24'hFF0000;
    send_frame(2'd1, 40, 1);
    check_frame("overrun");
    chk("overrun_const_ymax", 64'(by_max[9:0]), 64'd0);

    // Short frame
    fill_bg(5);
    px[4] = 24'h0000FF;
    send_frame(2'd0, 5, 1);
    check_frame("short");
    chk("short_const", 64'({bfound, bx_min[21:11], bx_min[10:0]}), 64'({2'b10, 11'd4, 11'd0}));

    // Overlay mode (acts as pass-through unless the overlay is built in)
    fill_bg(32);
    send_frame(2'd3, 32, 1);
    check_frame("ovl");

    // Reset with a beat stuck in the output register
    fill_bg(4);
    send_frame(2'd0, 3, 0);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(px[3], 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    got_q.delete();
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, i == 2);
    fill_bg(32);
    px[0] = 24'hFF0000;
    send_frame(2'd2, 32, 1);
    check_frame("resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
